// File: rtl/reg_context_engine_pkg.sv
// Shared types and width defaults for the register context engine.
// Holds FSM state encoding and register file width defaults.
package reg_context_engine_pkg;

  localparam int DEF_BIT_WIDTH       = 32;
  localparam int DEF_REG_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_FIN     = 2'd3
  } ctx_state_e;

endpackage

// File: rtl/reg_context_xor.sv
// Running XOR accumulator of context data words.
// Ports: clk, reset (async high), i_clr, i_en, i_data, o_acc.
module reg_context_xor
  import reg_context_engine_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [BIT_WIDTH-1:0] i_data,
  output logic [BIT_WIDTH-1:0] o_acc
);

  logic [BIT_WIDTH-1:0] r_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/reg_context_engine.sv
// Register context save/restore engine: streams all N registers out
// (save) or in (restore) in ascending index order, one word per cycle.
// Ports: clk, reset (async high), cmd_valid/cmd_save/cmd_ready command,
// rf_rd_ind/rf_rd_data read port, rf_wr_en/rf_wr_ind/rf_wr_data write
// port, out_* save stream, in_* restore stream, done pulse, err (sticky).
// Macro REG_CONTEXT_CHECKSUM_EN adds an XOR checksum word and err port.
module reg_context_engine
  import reg_context_engine_pkg::*;
#(
  parameter int BIT_WIDTH       = DEF_BIT_WIDTH,
  parameter int REG_INDEX_WIDTH = DEF_REG_INDEX_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  input  logic                       cmd_save,
  output logic                       cmd_ready,
  output logic [REG_INDEX_WIDTH-1:0] rf_rd_ind,
  input  logic [BIT_WIDTH-1:0]       rf_rd_data,
  output logic                       rf_wr_en,
  output logic [REG_INDEX_WIDTH-1:0] rf_wr_ind,
  output logic [BIT_WIDTH-1:0]       rf_wr_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BIT_WIDTH-1:0]       out_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BIT_WIDTH-1:0]       in_data,
  output logic                       done
`ifdef REG_CONTEXT_CHECKSUM_EN
  ,
  output logic                       err
`endif
);

  localparam logic [REG_INDEX_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [REG_INDEX_WIDTH-1:0] IDX_ONE  =
    REG_INDEX_WIDTH'(1);

  ctx_state_e                 r_state;
  ctx_state_e                 w_state_nx;
  logic [REG_INDEX_WIDTH-1:0] r_idx;
  logic [REG_INDEX_WIDTH-1:0] w_idx_nx;
  logic                       w_accept;
  logic                       w_out_hs;
  logic                       w_in_hs;
  logic                       w_hs;
  logic                       w_last;

  assign w_out_hs = (r_state == ST_SAVE) && out_ready;
  assign w_in_hs  = (r_state == ST_RESTORE) && in_valid;
  assign w_hs     = w_out_hs | w_in_hs;
  assign w_last   = (r_idx == IDX_LAST);

`ifdef REG_CONTEXT_CHECKSUM_EN
  // r_ck marks the extra checksum-word phase after index N-1.
  logic                 r_ck;
  logic                 w_ck_nx;
  logic                 r_err;
  logic                 w_err_nx;
  logic [BIT_WIDTH-1:0] w_acc;
  logic [BIT_WIDTH-1:0] w_word;

  assign w_word = (r_state == ST_SAVE) ? rf_rd_data : in_data;

  reg_context_xor #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_xor (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_accept),
    .i_en  (w_hs & ~r_ck),
    .i_data(w_word),
    .o_acc (w_acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ck  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ck  <= w_ck_nx;
      r_err <= w_err_nx;
    end
  end

  assign err      = r_err;
  assign out_data = r_ck ? w_acc : rf_rd_data;
  assign rf_wr_en = w_in_hs & ~r_ck;
`else
  assign out_data = rf_rd_data;
  assign rf_wr_en = w_in_hs;
`endif

  assign rf_rd_ind  = r_idx;
  assign rf_wr_ind  = r_idx;
  assign rf_wr_data = in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_accept   = 1'b0;
    cmd_ready  = 1'b0;
    out_valid  = 1'b0;
    in_ready   = 1'b0;
    done       = 1'b0;
`ifdef REG_CONTEXT_CHECKSUM_EN
    w_ck_nx    = r_ck;
    w_err_nx   = r_err;
`endif
    unique case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept   = 1'b1;
          w_idx_nx   = '0;
          w_state_nx = cmd_save ? ST_SAVE : ST_RESTORE;
`ifdef REG_CONTEXT_CHECKSUM_EN
          w_ck_nx    = 1'b0;
          w_err_nx   = 1'b0;
`endif
        end
      end
      ST_SAVE, ST_RESTORE: begin
        out_valid = (r_state == ST_SAVE);
        in_ready  = (r_state == ST_RESTORE);
        if (w_hs) begin
`ifdef REG_CONTEXT_CHECKSUM_EN
          if (r_ck) begin
            w_state_nx = ST_FIN;
            if ((r_state == ST_RESTORE) && (in_data != w_acc)) begin
              w_err_nx = 1'b1;
            end
          end else if (w_last) begin
            // idx stays at N-1; no wrap.
            w_ck_nx = 1'b1;
          end else begin
            w_idx_nx = r_idx + IDX_ONE;
          end
`else
          if (w_last) begin
            w_state_nx = ST_FIN;
          end else begin
            w_idx_nx = r_idx + IDX_ONE;
          end
`endif
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_context_engine.sv
// Scoreboard bench for reg_context_engine with attached register file.
// Build with REG_CONTEXT_CHECKSUM_EN to cover the checksum variant.
`timescale 1ns/1ps
module tb_reg_context_engine;

  localparam int BW = 32;
  localparam int IW = 4;
  localparam int N  = 16;
`ifdef REG_CONTEXT_CHECKSUM_EN
  localparam int CKW = 1;
`else
  localparam int CKW = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_save = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          cmd_ready;
  logic [IW-1:0] rf_rd_ind;
  logic [BW-1:0] rf_rd_data;
  logic          rf_wr_en;
  logic [IW-1:0] rf_wr_ind;
  logic [BW-1:0] rf_wr_data;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          in_ready;
  logic          done;
`ifdef REG_CONTEXT_CHECKSUM_EN
  logic          err;
`endif

  reg_context_engine #(
    .BIT_WIDTH(BW),
    .REG_INDEX_WIDTH(IW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_save  (cmd_save),
    .cmd_ready (cmd_ready),
    .rf_rd_ind (rf_rd_ind),
    .rf_rd_data(rf_rd_data),
    .rf_wr_en  (rf_wr_en),
    .rf_wr_ind (rf_wr_ind),
    .rf_wr_data(rf_wr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .done      (done)
`ifdef REG_CONTEXT_CHECKSUM_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  // register file model, bulk-loadable from pre[]
  logic [BW-1:0] rf  [N];
  logic [BW-1:0] pre [N];
  logic [BW-1:0] m   [N];
  logic          load = 1'b0;

  assign rf_rd_data = rf[rf_rd_ind];

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++) rf[i] <= pre[i];
    end else if (rf_wr_en) begin
      rf[rf_wr_ind] <= rf_wr_data;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  // scoreboard
  logic [BW-1:0] exp_q [$];
  int hs_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_edge = 0;
  int acc_cyc = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (hs_cnt < N) chk("rd_idx", 32'(rf_rd_ind), hs_cnt);
        if (exp_q.size() == 0) bad("save_extra_word", out_data);
        else chk("save_word", out_data, exp_q.pop_front());
        hs_cnt++;
      end
      if (rf_wr_en) begin
        chk("wr_in_save", {31'd0, out_valid}, 0);
        chk("wr_idx", 32'(rf_wr_ind), wr_cnt);
        if (exp_q.size() == 0) bad("restore_extra_write", rf_wr_data);
        else chk("restore_word", rf_wr_data, exp_q.pop_front());
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc + 1;
      end
    end
  end

  task automatic preload(input bit rnd);
    for (int i = 0; i < N; i++) begin
      pre[i] = rnd ? $urandom : 32'h100 + i;
      m[i] = pre[i];
    end
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic start_cmd(input bit save, input bit hold);
    hs_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1;
    cmd_save = save;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = hold;
    chk("cmd_ready_busy", {31'd0, cmd_ready}, 0);
`ifdef REG_CONTEXT_CHECKSUM_EN
    chk("err_clear_on_accept", {31'd0, err}, 0);
`endif
  endtask

  // mode 0: always ready, 1: stall 5 at idx 7, 2: random, 3: hold cmd
  task automatic save_run(input int mode);
    logic [BW-1:0] x;
    int stall;
    x = '0;
    stall = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(m[i]);
      x ^= m[i];
    end
`ifdef REG_CONTEXT_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    out_ready = 1'b1;
    start_cmd(1'b1, mode == 3);
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      if (mode == 1 && hs_cnt == 7 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else if (mode == 2) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (mode == 1 && !out_ready) begin
        chk("stall_data", out_data, m[7]);
        chk("stall_idx", 32'(rf_rd_ind), 7);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (done_cnt == 0) begin
      bad("save_timeout", 32'(hs_cnt));
    end else if (mode == 2) begin
      chk("save_lat_min", {31'd0, (done_edge - acc_cyc) >= N + 1 + CKW}, 1);
    end else begin
      chk("save_latency", done_edge - acc_cyc,
          N + 1 + CKW + (mode == 1 ? 5 : 0));
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("save_done_once", done_cnt, 1);
    chk("save_no_writes", wr_cnt, 0);
    chk("save_words", hs_cnt, N + CKW);
    chk("save_queue_empty", exp_q.size(), 0);
    chk("save_idle", {31'd0, cmd_ready}, 1);
  endtask

  // mode 0: 0xA000+i, in_valid toggling; 1: random; 2: reset at idx 5
  task automatic restore_run(input int mode, input bit corrupt);
    logic [BW-1:0] w [N];
    logic [BW-1:0] stim [$];
    logic [BW-1:0] x;
    bit hs;
    bit aborted;
    x = '0;
    aborted = 1'b0;
    exp_q.delete();
    stim.delete();
    for (int i = 0; i < N; i++) begin
      w[i] = (mode == 1) ? $urandom : 32'hA000 + i;
      x ^= w[i];
      exp_q.push_back(w[i]);
      stim.push_back(w[i]);
    end
`ifdef REG_CONTEXT_CHECKSUM_EN
    stim.push_back(corrupt ? x ^ 32'h0000_0100 : x);
`endif
    in_valid = 1'b0;
    start_cmd(1'b0, 1'b0);
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      if (mode == 2 && wr_cnt == 5) begin
        reset = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (stim.size() > 0) begin
        in_data = stim[0];
        if (mode == 0) in_valid = (c % 2 == 0);
        else if (mode == 1) in_valid = 1'($urandom_range(0, 1));
        else in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) void'(stim.pop_front());
    end
    if (aborted) begin
      #1;
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      chk("rst_wr_en", {31'd0, rf_wr_en}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_wr_ind", 32'(rf_wr_ind), 0);
      in_valid = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
      end
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 5; i++) m[i] = w[i];
      chk("rst_writes", wr_cnt, 5);
      chk("rst_no_done", done_cnt, 0);
    end else begin
      in_valid = 1'b0;
      if (done_cnt == 0) bad("restore_timeout", 32'(wr_cnt));
      repeat (2) begin
        @(posedge clk); #1;
      end
      for (int i = 0; i < N; i++) m[i] = w[i];
      chk("restore_writes", wr_cnt, N);
      chk("restore_done_once", done_cnt, 1);
      chk("restore_queue_empty", exp_q.size(), 0);
`ifdef REG_CONTEXT_CHECKSUM_EN
      chk("restore_err", {31'd0, err}, {31'd0, corrupt});
`endif
    end
    for (int i = 0; i < N; i++) chk("rf_contents", rf[i], m[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 1);
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 0);
    chk("reset_wr_en", {31'd0, rf_wr_en}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_rd_ind", 32'(rf_rd_ind), 0);
    chk("reset_wr_ind", 32'(rf_wr_ind), 0);
`ifdef REG_CONTEXT_CHECKSUM_EN
    chk("reset_err", {31'd0, err}, 0);
`endif
    @(posedge clk); #1;
    preload(1'b0);
    reset = 1'b0;
    save_run(0);
    save_run(1);
    restore_run(0, 1'b0);
    save_run(3);
    preload(1'b0);
    restore_run(2, 1'b0);
    save_run(0);
`ifdef REG_CONTEXT_CHECKSUM_EN
    restore_run(0, 1'b1);
    save_run(0);
`endif
    for (int k = 0; k < 3; k++) begin
      preload(1'b1);
      save_run(2);
      restore_run(1, 1'($urandom_range(0, 1)));
      save_run(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
